// File: rtl/avalon_dram_pkg.sv
// Shared types and constants for the NoC-to-Avalon DRAM burst controller.
// Provides `MSG_TYPE_WIDTH when the surrounding NoC build has not defined it.
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif

package avalon_dram_pkg;

    localparam int MSG_TYPE_W = `MSG_TYPE_WIDTH;

    // NoC message encodings handled by the controller; everything else is dropped.
    localparam logic [MSG_TYPE_W-1:0] MSG_TYPE_LOAD_MEM  = MSG_TYPE_W'(19);
    localparam logic [MSG_TYPE_W-1:0] MSG_TYPE_STORE_MEM = MSG_TYPE_W'(20);

    typedef enum logic [2:0] {
        READY,
        RD_HDR,
        RD_STREAM,
        WR_DATA,
        WR_RESP
    } state_e;

    localparam int DEFAULT_BURST_LEN = 4;

    // Width of a beat-within-line index; a 1-beat burst still needs one bit.
    function automatic int beat_idx_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/avalon_dram_burst_ctrl_credit.sv
// Read-buffer credit counter: +K when a read burst is accepted, -1 per beat
// popped to the NoC. Issue policy selected by AVALON_DRAM_PIPELINED_RD_EN:
// defined -> any burst that still fits in the buffer, undefined -> one burst
// at a time (buffer must be empty of this controller's beats).
module dram_credit_counter
#(
    parameter int K     = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
)
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic can_issue_o
);

    localparam logic [CNT_W-1:0] K_C   = CNT_W'(K);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next credit value; simultaneous issue and pop nets to K-1.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && dec_i) begin
            cnt_d = cnt_q + K_C - ONE_C;
        end else if (inc_i) begin
            cnt_d = cnt_q + K_C;
        end else if (dec_i) begin
            cnt_d = cnt_q - ONE_C;
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef AVALON_DRAM_PIPELINED_RD_EN
    localparam int               EXT_W     = CNT_W + 1;
    localparam logic [EXT_W-1:0] K_EXT     = EXT_W'(K);
    localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(DEPTH);

    assign can_issue_o = ({1'b0, cnt_q} + K_EXT) <= DEPTH_EXT;
`else
    assign can_issue_o = (cnt_q == '0);
`endif

endmodule

// File: rtl/avalon_dram_burst_ctrl.sv
// Control FSM of the NoC-to-Avalon DRAM controller. Turns LOAD_MEM/STORE_MEM
// headers of N lines into N Avalon bursts of BURST_LEN beats; all data moves
// through the datapath. Optional AVALON_DRAM_PIPELINED_RD_EN lets several read
// bursts be outstanding (see dram_credit_counter).
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  READY     | accept a header flit, latch line count
//  RD_HDR    | send the load response header
//  RD_STREAM | issue read bursts under credit, stream buffered beats out
//  WR_DATA   | forward each request flit as one Avalon write beat
//  WR_RESP   | send the store response header
module avalon_dram_burst_ctrl
    import avalon_dram_pkg::*;
#(
    parameter int BURST_LEN    = DEFAULT_BURST_LEN,
    parameter int BURSTCOUNT_W = $clog2(BURST_LEN) + 1,
    parameter int LINES_W      = 8,
    parameter int RD_BUF_DEPTH = 16
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        noc0_ctovr_controller_val,
    output logic                        controller_noc0_ctovr_rdy,
    output logic                        controller_noc0_vrtoc_val,
    input  logic                        noc0_vrtoc_controller_rdy,
    input  logic [`MSG_TYPE_WIDTH-1:0]  datap_ctrl_msg_type,
    input  logic [LINES_W-1:0]          datap_ctrl_num_lines,
    output logic                        avm_read,
    output logic                        avm_write,
    output logic [BURSTCOUNT_W-1:0]     avm_burstcount,
    input  logic                        avm_waitrequest,
    input  logic                        avm_readdatavalid,
    output logic                        ctrl_datap_store_hdr_flit,
    output logic                        ctrl_datap_send_hdr_flit,
    output logic                        ctrl_datap_incr_rd_addr,
    output logic                        ctrl_datap_incr_wr_addr,
    output logic                        ctrl_datap_rdbuf_deq,
    input  logic                        datap_ctrl_rdbuf_empty,
    output logic                        ctrl_err_unsupported
);

    localparam int BL_LOG2  = $clog2(BURST_LEN);
    localparam int BEATS_W  = LINES_W + BL_LOG2;
    localparam int BIDX_W   = beat_idx_w(BURST_LEN);
    localparam int CREDIT_W = $clog2(RD_BUF_DEPTH + 1);

    localparam logic [BIDX_W-1:0]       LAST_BEAT = BIDX_W'(BURST_LEN - 1);
    localparam logic [BURSTCOUNT_W-1:0] BURST_BC  = BURSTCOUNT_W'(BURST_LEN);

    state_e               state_q, state_d;
    logic [LINES_W-1:0]   num_lines_q, num_lines_d;
    logic [LINES_W-1:0]   lines_q, lines_d;        // lines issued (load) or written (store)
    logic [BEATS_W-1:0]   beats_q, beats_d;        // read beats sent to the NoC
    logic [BIDX_W-1:0]    beat_idx_q, beat_idx_d;  // write beat within current line
    logic [BEATS_W-1:0]   beats_total;
    logic                 can_issue;
    logic                 rd_accept;

    // Read beats land in the datapath buffer; the FSM only sees them through
    // rdbuf_empty and the credit count, so the strobe itself is not needed here.
    logic unused_rdv;
    assign unused_rdv = avm_readdatavalid;

    assign beats_total = BEATS_W'(num_lines_q) << BL_LOG2;

    dram_credit_counter #(
        .K     (BURST_LEN),
        .DEPTH (RD_BUF_DEPTH),
        .CNT_W (CREDIT_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (rd_accept),
        .dec_i       (ctrl_datap_rdbuf_deq),
        .can_issue_o (can_issue)
    );

    // Next-state, counter updates and all outputs; reset forces outputs low.
    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        lines_d     = lines_q;
        beats_d     = beats_q;
        beat_idx_d  = beat_idx_q;

        controller_noc0_ctovr_rdy = 1'b0;
        controller_noc0_vrtoc_val = 1'b0;
        avm_read                  = 1'b0;
        avm_write                 = 1'b0;
        avm_burstcount            = '0;
        ctrl_datap_store_hdr_flit = 1'b0;
        ctrl_datap_send_hdr_flit  = 1'b0;
        ctrl_datap_incr_rd_addr   = 1'b0;
        ctrl_datap_incr_wr_addr   = 1'b0;
        ctrl_datap_rdbuf_deq      = 1'b0;
        ctrl_err_unsupported      = 1'b0;
        rd_accept                 = 1'b0;

        unique case (state_q)
            READY: begin
                controller_noc0_ctovr_rdy = 1'b1;
                if (noc0_ctovr_controller_val) begin
                    ctrl_datap_store_hdr_flit = 1'b1;
                    num_lines_d = datap_ctrl_num_lines;
                    lines_d     = '0;
                    beats_d     = '0;
                    beat_idx_d  = '0;
                    if (datap_ctrl_msg_type == MSG_TYPE_LOAD_MEM) begin
                        state_d = RD_HDR;
                    end else if (datap_ctrl_msg_type == MSG_TYPE_STORE_MEM) begin
                        state_d = (datap_ctrl_num_lines == '0) ? WR_RESP : WR_DATA;
                    end else begin
                        ctrl_err_unsupported = 1'b1;
                    end
                end
            end

            RD_HDR: begin
                controller_noc0_vrtoc_val = 1'b1;
                ctrl_datap_send_hdr_flit  = 1'b1;
                if (noc0_vrtoc_controller_rdy) begin
                    state_d = (num_lines_q == '0) ? READY : RD_STREAM;
                end
            end

            RD_STREAM: begin
                // Issue side: credit can only grow while a read waits, so the
                // strobe is never withdrawn under waitrequest.
                avm_read  = (lines_q < num_lines_q) && can_issue;
                rd_accept = avm_read && !avm_waitrequest;
                if (rd_accept) begin
                    lines_d                 = lines_q + 1'b1;
                    ctrl_datap_incr_rd_addr = 1'b1;
                end
                // Send side runs in parallel with issue.
                controller_noc0_vrtoc_val = !datap_ctrl_rdbuf_empty;
                ctrl_datap_rdbuf_deq      = controller_noc0_vrtoc_val && noc0_vrtoc_controller_rdy;
                if (ctrl_datap_rdbuf_deq) begin
                    beats_d = beats_q + 1'b1;
                    if ((beats_q + 1'b1) == beats_total) begin
                        state_d = READY;
                    end
                end
            end

            WR_DATA: begin
                avm_write                 = noc0_ctovr_controller_val;
                controller_noc0_ctovr_rdy = !avm_waitrequest;
                if (noc0_ctovr_controller_val && !avm_waitrequest) begin
                    if (beat_idx_q == LAST_BEAT) begin
                        beat_idx_d              = '0;
                        lines_d                 = lines_q + 1'b1;
                        ctrl_datap_incr_wr_addr = 1'b1;
                        if ((lines_q + 1'b1) == num_lines_q) begin
                            state_d = WR_RESP;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
            end

            WR_RESP: begin
                controller_noc0_vrtoc_val = 1'b1;
                ctrl_datap_send_hdr_flit  = 1'b1;
                if (noc0_vrtoc_controller_rdy) begin
                    state_d = READY;
                end
            end

            default: state_d = READY;
        endcase

        if (rst) begin
            controller_noc0_ctovr_rdy = 1'b0;
            controller_noc0_vrtoc_val = 1'b0;
            avm_read                  = 1'b0;
            avm_write                 = 1'b0;
            ctrl_datap_store_hdr_flit = 1'b0;
            ctrl_datap_send_hdr_flit  = 1'b0;
            ctrl_datap_incr_rd_addr   = 1'b0;
            ctrl_datap_incr_wr_addr   = 1'b0;
            ctrl_datap_rdbuf_deq      = 1'b0;
            ctrl_err_unsupported      = 1'b0;
            rd_accept                 = 1'b0;
        end

        avm_burstcount = (avm_read || avm_write) ? BURST_BC : '0;
    end

    // State and counter registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= READY;
            num_lines_q <= '0;
            lines_q     <= '0;
            beats_q     <= '0;
            beat_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_lines_q <= num_lines_d;
            lines_q     <= lines_d;
            beats_q     <= beats_d;
            beat_idx_q  <= beat_idx_d;
        end
    end

endmodule
